// File: rtl/leitor_calculadora_pkg.sv
// Shared definitions for the read-side sequencer: state encoding and default widths.
package leitor_calculadora_pkg;

    localparam int DEF_W  = 32;
    localparam int DEF_AW = 5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_SEND = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/leitor_calculadora_if.sv
// Valid/ready output stream carrying one captured word and its address.
interface leitor_calculadora_if #(
    parameter int W  = 32,
    parameter int AW = 5
);
    logic          valid;
    logic          ready;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/leitor_calculadora.sv
// Sweeps the calculator bank's read address over [first..last] (wrapping),
// presents each returned word on a valid/ready stream and accumulates a
// modulo-2^W running sum of the accepted words.
module leitor_calculadora
    import leitor_calculadora_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int AW = DEF_AW
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [AW-1:0]         first,
    input  logic [AW-1:0]         last,
    output logic [AW-1:0]         read,
    input  logic [W-1:0]          data,
    leitor_calculadora_if.master  o,
    output logic [W-1:0]          sum,
    output logic                  busy,
    output logic                  done
);

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [2:0]    state_q,    state_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic [AW-1:0] end_addr_q, end_addr_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [W-1:0]  sum_q,      sum_d;
    logic          valid_q,    valid_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;

    // Next-state, address, capture and accumulation logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        end_addr_d = end_addr_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        sum_d      = sum_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d     = first;
                    end_addr_d = last;
                    sum_d      = {W{1'b0}};
                    state_d    = ST_ADDR;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_ADDR: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Bank has one-cycle read latency, so data is valid now.
                out_data_d = data;
                out_addr_d = addr_q;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (o.ready) begin
                    sum_d = sum_q + out_data_q;
                    if (addr_q == end_addr_q) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = ST_ADDR;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status outputs are registered from the next state so they align with it.
        valid_d = (state_d == ST_SEND);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= {AW{1'b0}};
            end_addr_q <= {AW{1'b0}};
            out_addr_q <= {AW{1'b0}};
            out_data_q <= {W{1'b0}};
            sum_q      <= {W{1'b0}};
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            end_addr_q <= end_addr_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            sum_q      <= sum_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign read    = addr_q;
    assign o.valid = valid_q;
    assign o.addr  = out_addr_q;
    assign o.data  = out_data_q;
    assign sum     = sum_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_leitor_calculadora.sv
// Self-checking bench for leitor_calculadora with a one-cycle-latency bank model.
module tb_leitor_calculadora;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  first, last, read;
    logic [31:0] data;
    logic [31:0] sum;
    logic        busy, done;
    logic [31:0] bank [32];

    int vectors = 0;
    int miscompares = 0;

    leitor_calculadora_if #(.W(32), .AW(5)) ob ();

    leitor_calculadora #(.W(32), .AW(5)) dut (
        .clock (clock), .reset (reset), .start (start),
        .first (first), .last (last), .read (read), .data (data),
        .o (ob), .sum (sum), .busy (busy), .done (done)
    );

    always #5 clock = ~clock;

    // Behavioural bank: registered read, one cycle of latency.
    always @(posedge clock) data <= bank[read];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One sweep: expected words are bank[first+i mod 32] for i < word count.
    task automatic sweep(input logic [4:0] f, input logic [4:0] l, input int stall_word,
                         input int stall_len, input bit rnd_ready, input int inject_t);
        int n, t, idx, stalls, held, done_t;
        logic [4:0]  exp_a;
        logic [31:0] es;
        bit rdy;
        n = ((int'(l) - int'(f) + 32) % 32) + 1;
        es = 32'd0; idx = 0; stalls = 0; held = 0; done_t = -1;
        @(negedge clock);
        start = 1'b1; first = f; last = l;
        @(negedge clock);
        start = 1'b0;
        t = 1;
        chk("busy_k1", {31'd0, busy}, 32'd1);
        chk("read_k1", {27'd0, read}, {27'd0, f});
        while (t < 400) begin
            chk("done_and_valid", {31'd0, done & ob.valid}, 32'd0);
            if (t == inject_t) begin
                start = 1'b1; first = 5'd10; last = 5'd12;
            end else begin
                start = 1'b0;
            end
            if (ob.valid) begin
                exp_a = f + idx[4:0];
                chk("out_addr", {27'd0, ob.addr}, {27'd0, exp_a});
                chk("out_data", ob.data, bank[exp_a]);
                chk("read_hold", {27'd0, read}, {27'd0, exp_a});
                if (idx == stall_word && held < stall_len) rdy = 1'b0;
                else if (rnd_ready) rdy = ($urandom_range(0, 2) != 0);
                else rdy = 1'b1;
                ob.ready = rdy;
                if (rdy) begin
                    chk("word_time", t, 3 + 3 * idx + stalls);
                    es = es + bank[exp_a];
                    idx++;
                end else begin
                    stalls++;
                    held++;
                end
            end else begin
                ob.ready = rnd_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
            end
            if (done) begin
                done_t = t;
                chk("sum_at_done", sum, es);
                break;
            end
            @(negedge clock);
            t++;
        end
        start = 1'b0;
        chk("word_count", idx, n);
        chk("done_time", done_t, 3 * n + 1 + stalls);
        @(negedge clock);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("valid_after", {31'd0, ob.valid}, 32'd0);
        chk("sum_hold", sum, es);
        ob.ready = 1'b1;
    endtask

    initial begin
        int w;
        reset = 1'b0; start = 1'b0; first = 5'd0; last = 5'd0; ob.ready = 1'b1;
        for (int i = 0; i < 32; i++) bank[i] = 32'd3 * i;
        @(negedge clock); @(negedge clock);
        chk("rst_read", {27'd0, read}, 32'd0);
        chk("rst_valid", {31'd0, ob.valid}, 32'd0);
        chk("rst_addr", {27'd0, ob.addr}, 32'd0);
        chk("rst_data", ob.data, 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b1;

        // Basic sweep, wrap sweep, backpressure on word 2.
        sweep(5'd0, 5'd3, -1, 0, 1'b0, -1);
        chk("basic_sum", sum, 32'd18);
        sweep(5'd30, 5'd1, -1, 0, 1'b0, -1);
        chk("wrap_sum", sum, 32'd186);
        sweep(5'd0, 5'd3, 2, 5, 1'b0, -1);
        chk("bp_sum", sum, 32'd18);

        // Single word with all-ones, twice, then a wrapping 2-word sum.
        bank[7] = 32'hFFFF_FFFF; bank[8] = 32'd2;
        sweep(5'd7, 5'd7, -1, 0, 1'b0, -1);
        chk("single1_sum", sum, 32'hFFFF_FFFF);
        sweep(5'd7, 5'd7, -1, 0, 1'b0, -1);
        chk("single2_sum", sum, 32'hFFFF_FFFF);
        sweep(5'd7, 5'd8, -1, 0, 1'b0, -1);
        chk("overflow_sum", sum, 32'd1);

        // Start while busy must be ignored.
        sweep(5'd0, 5'd3, -1, 0, 1'b0, 5);
        chk("ignored_start_sum", sum, 32'd18);

        // Reset mid-sweep while presenting a word.
        @(negedge clock);
        start = 1'b1; first = 5'd0; last = 5'd3;
        @(negedge clock);
        start = 1'b0; ob.ready = 1'b0;
        w = 0;
        while (!ob.valid && w < 10) begin
            @(negedge clock);
            w++;
        end
        chk("reach_send", {31'd0, ob.valid}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, ob.valid}, 32'd0);
        chk("mid_rst_read", {27'd0, read}, 32'd0);
        chk("mid_rst_addr", {27'd0, ob.addr}, 32'd0);
        chk("mid_rst_data", ob.data, 32'd0);
        chk("mid_rst_sum", sum, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("mid_rst_done", {31'd0, done}, 32'd0);
        end
        reset = 1'b1; ob.ready = 1'b1;
        sweep(5'd0, 5'd3, -1, 0, 1'b0, -1);
        chk("post_rst_sum", sum, 32'd18);

        // Randomized banks, ranges and backpressure.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 32; i++) bank[i] = $urandom;
            sweep(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), -1, 0, 1'b1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
